// File: rtl/divider_wrapper_block_pkg.sv
// divider_wrapper_block_pkg: shared widths and FSM encoding for the execution-unit wrappers
package divider_wrapper_block_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int TAG_W_DEF = 6;
   typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/divider_wrapper_block_div_core.sv
// div_core: iterative restoring signed divider, one quotient bit per cycle
module div_core
   import divider_wrapper_block_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] quotient,
   output logic              valid
);
   localparam int CW = $clog2(DATA_W);
   logic run, neg, dz, ge;
   logic [CW-1:0] cnt;
   logic [DATA_W-1:0] q, rem, d, shifted, rem_n, q_n;
   // remainder stays below the divisor magnitude, so its MSB is always clear before the shift
   always_comb begin
      shifted = {rem[DATA_W-2:0], q[DATA_W-1]};
      ge = shifted >= d;
      rem_n = ge ? shifted - d : shifted;
      q_n = {q[DATA_W-2:0], ge};
      quotient = dz ? '1 : (neg ? -q_n : q_n);
      valid = run && cnt == CW'(DATA_W - 1);
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         run <= 1'b0;
         neg <= 1'b0;
         dz <= 1'b0;
         cnt <= '0;
         q <= '0;
         rem <= '0;
         d <= '0;
      end else if (start) begin
         run <= 1'b1;
         neg <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
         dz <= divisor == '0;
         cnt <= '0;
         q <= dividend[DATA_W-1] ? -dividend : dividend;
         rem <= '0;
         d <= divisor[DATA_W-1] ? -divisor : divisor;
      end else if (run) begin
         q <= q_n;
         rem <= rem_n;
         cnt <= cnt + 1'b1;
         run <= !valid;
      end
   end
endmodule

// File: rtl/divider_wrapper_block.sv
// divider_wrapper_block: issue/tag/busy/done wrapper around the iterative divide core
module divider_wrapper_block
   import divider_wrapper_block_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issuediv_enable,
   input  logic [DATA_W-1:0] issuediv_rsdata,
   input  logic [DATA_W-1:0] issuediv_rtdata,
   input  logic [TAG_W-1:0]  issuediv_rdtag,
   output logic              issuediv_busy,
   output logic [DATA_W-1:0] issuediv_out,
   output logic [TAG_W-1:0]  issuediv_rdtag_out,
   output logic              issuediv_done
);
   state_t state;
   logic [TAG_W-1:0] tag;
   logic start, core_valid;
   logic [DATA_W-1:0] core_q;
   assign start = state == IDLE && issuediv_enable;
   div_core #(.DATA_W(DATA_W)) u_core (
      .clk(clk),
      .reset(reset),
      .start(start),
      .dividend(issuediv_rsdata),
      .divisor(issuediv_rtdata),
      .quotient(core_q),
      .valid(core_valid)
   );
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         tag <= '0;
         issuediv_busy <= 1'b0;
         issuediv_done <= 1'b0;
         issuediv_out <= '0;
         issuediv_rdtag_out <= '0;
      end else begin
         issuediv_done <= 1'b0;
         case (state)
            IDLE: if (issuediv_enable) begin
               tag <= issuediv_rdtag;
               issuediv_busy <= 1'b1;
               state <= RUN;
            end
            RUN: if (core_valid) begin
               issuediv_out <= core_q;
               issuediv_rdtag_out <= tag;
               issuediv_done <= 1'b1;
               issuediv_busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_divider_wrapper_block.sv
// tb_divider_wrapper_block: directed vectors for latency, signed results, corner cases and reset abort
module tb_divider_wrapper_block;
   logic clk = 1'b0, reset = 1'b0, enable = 1'b0;
   logic [31:0] rs = '0, rt = '0;
   logic [5:0] tg = '0;
   logic busy, done;
   logic [31:0] q;
   logic [5:0] tq;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   divider_wrapper_block dut (
      .clk(clk),
      .reset(reset),
      .issuediv_enable(enable),
      .issuediv_rsdata(rs),
      .issuediv_rtdata(rt),
      .issuediv_rdtag(tg),
      .issuediv_busy(busy),
      .issuediv_out(q),
      .issuediv_rdtag_out(tq),
      .issuediv_done(done)
   );
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [5:0] t);
      enable = 1'b1;
      rs = a;
      rt = b;
      tg = t;
   endtask
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] t);
      drive(a, b, t);
      step();
      enable = 1'b0;
   endtask
   task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] t, input logic [31:0] exp);
      int n, nb;
      issue(a, b, t);
      n = 1;
      nb = 0;
      while (!done && n < 40) begin
         nb += int'(busy);
         step();
         n++;
      end
      check({nm, "_lat"}, 64'(n), 64'd33);
      check({nm, "_busy_cycles"}, 64'(nb), 64'd32);
      check({nm, "_busy_at_done"}, 64'(busy), 64'd0);
      check({nm, "_out"}, 64'(q), 64'(exp));
      check({nm, "_tag"}, 64'(tq), 64'(t));
      step();
      check({nm, "_done_pulse"}, 64'(done), 64'd0);
      check({nm, "_hold"}, 64'({q, tq}), 64'({exp, t}));
   endtask
   initial begin
      int n, nd;
      #1;
      drive(32'd9, 32'd3, 6'h15);
      repeat (3) step();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_out", 64'({q, tq}), 64'd0);
      enable = 1'b0;
      reset = 1'b1;
      step();
      check("post_rst_idle", 64'(busy), 64'd0);
      run_div("p6d2", 32'd6, 32'd2, 6'h00, 32'd3);
      run_div("m7d2", 32'hFFFF_FFF9, 32'd2, 6'h0E, 32'hFFFF_FFFD);
      run_div("div0", 32'd15, 32'd0, 6'h0B, 32'hFFFF_FFFF);
      run_div("negdiv0", 32'hFFFF_FFFF, 32'd0, 6'h03, 32'hFFFF_FFFF);
      run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 6'h3F, 32'h8000_0000);
      run_div("p100dm7", 32'd100, 32'hFFFF_FFF9, 6'h04, 32'hFFFF_FFF2);
      run_div("m100dm7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 6'h21, 32'd14);
      issue(32'd77, 32'd7, 6'h01);
      n = 1;
      while (n < 33) begin
         if (n == 10) drive(32'd100, 32'd10, 6'h02);
         step();
         enable = 1'b0;
         n++;
      end
      check("b2b_first_done", 64'(done), 64'd1);
      check("b2b_first_out", 64'({q, tq}), 64'({32'd11, 6'h01}));
      drive(32'd100, 32'd10, 6'h02);
      step();
      enable = 1'b0;
      n = 34;
      check("b2b_accept_busy", 64'(busy), 64'd1);
      while (!done && n < 80) begin
         if (n == 50) check("b2b_hold_mid", 64'(q), 64'd11);
         step();
         n++;
      end
      check("b2b_second_lat", 64'(n), 64'd66);
      check("b2b_second_out", 64'({q, tq}), 64'({32'd10, 6'h02}));
      step();
      issue(32'd6, 32'd2, 6'h07);
      n = 1;
      while (n < 15) begin
         step();
         n++;
      end
      check("abort_busy_before", 64'(busy), 64'd1);
      reset = 1'b0;
      drive(32'd50, 32'd5, 6'h09);
      step();
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_out", 64'({q, tq}), 64'd0);
      step();
      enable = 1'b0;
      reset = 1'b1;
      nd = 0;
      repeat (40) begin
         step();
         nd += int'(done);
      end
      check("abort_no_done", 64'(nd), 64'd0);
      check("abort_idle", 64'(busy), 64'd0);
      run_div("recover", 32'd1000, 32'd3, 6'h05, 32'd333);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
